am_envelope_demod: RTL

- Parametrised next-generation AM demodulator. Takes signed I/Q baseband samples at a strobed sample rate and computes the envelope magnitude floor(sqrt(I²+Q²)) with one shared multiplier and an iterative bit-serial square root.
- Optionally removes the carrier DC level with a first-order leaky average, then presents a signed audio sample with a valid strobe.
- Sits between the decimating I/Q filter chain and the audio output path, in the fast system clock domain.

---
 rtl/am_envelope_demod_pkg.sv | 19 +
 rtl/am_envelope_demod_if.sv | 27 ++
 rtl/am_envelope_demod_iter_sqrt.sv | 64 ++++++
 rtl/am_envelope_demod.sv | 120 ++++++++++++
 4 files changed

// File: rtl/am_envelope_demod_pkg.sv
// am_demod_pkg: shared definitions for the AM envelope demodulator.
// Contents: FSM state encoding and width helpers for the squared-sum datapath.
package am_demod_pkg;

    // Sample flow: capture -> I^2 -> +Q^2 -> bit-serial root -> DC removal.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ_I = 3'd1,
        SQ_Q = 3'd2,
        SQRT = 3'd3,
        DC   = 3'd4
    } state_t;

    // Width of a squared sample (and of the sum of two squares).
    function automatic int sq_w(input int in_w);
        return 2 * in_w;
    endfunction

endpackage

// File: rtl/am_envelope_demod_if.sv
// am_envelope_demod_if: sample-in / audio-out bundle for the AM demodulator.
//   master : sample source (drives in_valid, I_in, Q_in, dc_bypass)
//   slave  : demodulator   (drives in_ready, d_out, out_valid, overrun)
interface am_envelope_demod_if #(
    parameter int IN_W = 8
) ();
    localparam int OUT_W = IN_W + 1;

    logic                    in_valid;
    logic signed [IN_W-1:0]  I_in;
    logic signed [IN_W-1:0]  Q_in;
    logic                    dc_bypass;
    logic                    in_ready;
    logic signed [OUT_W-1:0] d_out;
    logic                    out_valid;
    logic                    overrun;

    modport master (
        output in_valid, I_in, Q_in, dc_bypass,
        input  in_ready, d_out, out_valid, overrun
    );

    modport slave (
        input  in_valid, I_in, Q_in, dc_bypass,
        output in_ready, d_out, out_valid, overrun
    );
endinterface

// File: rtl/am_envelope_demod_iter_sqrt.sv
// iter_sqrt: bit-serial restoring integer square root, one result bit per clock.
//   clk, rst_n  : clock, async active-low reset
//   i_start     : load i_radicand, clear root/remainder, begin iterating
//   i_radicand  : unsigned 2*ROOT_W-bit value
//   o_last      : high during the final iteration cycle (root complete after that edge)
//   o_root      : floor(sqrt(radicand)), valid once the last iteration has clocked
module iter_sqrt
    import am_demod_pkg::*;
#(
    parameter int ROOT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic [sq_w(ROOT_W)-1:0]       i_radicand,
    output logic                          o_last,
    output logic [ROOT_W-1:0]             o_root
);
    localparam int RAD_W = sq_w(ROOT_W);
    // Remainder never exceeds 2*root, so ROOT_W+2 bits hold the shifted value.
    localparam int REM_W = ROOT_W + 2;
    localparam int CNT_W = $clog2(ROOT_W);

    logic [RAD_W-1:0]  r_rad;
    logic [REM_W-1:0]  r_rem;
    logic [ROOT_W-1:0] r_root;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;

    logic [REM_W-1:0]  w_rem_sh;
    logic [REM_W-1:0]  w_trial;
    logic              w_fits;

    // Bring down the next two radicand bits and try subtracting 4*root+1.
    assign w_rem_sh = {r_rem[ROOT_W-1:0], r_rad[RAD_W-1 -: 2]};
    assign w_trial  = {r_root, 2'b01};
    assign w_fits   = (w_rem_sh >= w_trial);

    assign o_last = r_busy && (r_cnt == CNT_W'(ROOT_W - 1));
    assign o_root = r_root;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rad  <= i_radicand;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rad  <= r_rad << 2;
            r_rem  <= w_fits ? (w_rem_sh - w_trial) : w_rem_sh;
            r_root <= {r_root[ROOT_W-2:0], w_fits};
            r_cnt  <= r_cnt + 1'b1;
            if (o_last)
                r_busy <= 1'b0;
        end
    end
endmodule

// File: rtl/am_envelope_demod.sv
// am_envelope_demod: I/Q envelope detector with optional leaky-average DC removal.
//   clk, rst_n : system clock, async active-low reset
//   bus        : slave side of am_envelope_demod_if
//                in_valid/I_in/Q_in/dc_bypass in; in_ready, d_out, out_valid, overrun out
// One shared squarer computes I^2 then Q^2; iter_sqrt produces the magnitude
// over IN_W cycles; the DC stage subtracts acc>>DC_SHIFT and updates acc.
module am_envelope_demod
    import am_demod_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int DC_SHIFT = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    am_envelope_demod_if.slave   bus
);
    localparam int OUT_W = IN_W + 1;
    localparam int SQ_W  = sq_w(IN_W);
    localparam int ACC_W = IN_W + DC_SHIFT;

    state_t r_state, w_next;

    logic signed [IN_W-1:0]  r_i, r_q;
    logic                    r_byp;
    logic [SQ_W-1:0]         r_sum;
    logic [ACC_W-1:0]        r_acc;
    logic signed [OUT_W-1:0] r_dout;
    logic                    r_ovalid;
    logic                    r_overrun;

    logic signed [IN_W-1:0]  w_mul_op;
    logic signed [SQ_W-1:0]  w_op_ext;
    logic signed [SQ_W-1:0]  w_prod;
    logic [SQ_W-1:0]         w_sq;
    logic [SQ_W-1:0]         w_sum_next;
    logic                    w_sqrt_last;
    logic [IN_W-1:0]         w_mag;
    logic [IN_W-1:0]         w_avg;
    logic signed [OUT_W-1:0] w_mag_ext, w_avg_ext;
    logic [ACC_W-1:0]        w_acc_next;

    // Shared squarer: Q in SQ_Q, I otherwise. Sign-extend before multiplying so
    // (-2^(IN_W-1))^2 lands in range; the square is non-negative so the low
    // SQ_W bits are the exact unsigned result.
    assign w_mul_op   = (r_state == SQ_Q) ? r_q : r_i;
    assign w_op_ext   = SQ_W'(w_mul_op);
    assign w_prod     = w_op_ext * w_op_ext;
    assign w_sq       = $unsigned(w_prod);
    assign w_sum_next = r_sum + w_sq;

    // The root engine loads the completed sum on the same edge the sum register does.
    iter_sqrt #(.ROOT_W(IN_W)) u_sqrt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (r_state == SQ_Q),
        .i_radicand (w_sum_next),
        .o_last     (w_sqrt_last),
        .o_root     (w_mag)
    );

    // Leaky average: acc tracks mag<<DC_SHIFT; avg_q is its integer part.
    assign w_avg      = IN_W'(r_acc >> DC_SHIFT);
    assign w_mag_ext  = $signed({1'b0, w_mag});
    assign w_avg_ext  = $signed({1'b0, w_avg});
    assign w_acc_next = r_acc + ACC_W'(w_mag) - ACC_W'(w_avg);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = SQ_I;
            SQ_I:    w_next = SQ_Q;
            SQ_Q:    w_next = SQRT;
            SQRT:    if (w_sqrt_last) w_next = DC;
            DC:      w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i       <= '0;
            r_q       <= '0;
            r_byp     <= 1'b0;
            r_sum     <= '0;
            r_acc     <= '0;
            r_dout    <= '0;
            r_ovalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_ovalid  <= (r_state == DC);
            // A sample arriving while busy is dropped and flagged.
            r_overrun <= bus.in_valid && (r_state != IDLE);
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_i   <= bus.I_in;
                    r_q   <= bus.Q_in;
                    r_byp <= bus.dc_bypass;
                end
                SQ_I: r_sum <= w_sq;
                SQ_Q: r_sum <= w_sum_next;
                DC: begin
                    // Output uses the average from before this sample's update.
                    r_dout <= r_byp ? w_mag_ext : (w_mag_ext - w_avg_ext);
                    r_acc  <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.d_out     = r_dout;
    assign bus.out_valid = r_ovalid;
    assign bus.overrun   = r_overrun;
endmodule
